// File: rtl/pipe_pkg.sv
// Shared types and widths for the pipeline stall/flush controller.
package pipe_pkg;

    localparam int MCNT_W = 4;
    localparam int SCNT_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic mem_wb_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } pipe_ctrl_t;

endpackage

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply sequencer: keeps EX occupied until the product is ready.
module mul_sequencer
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic ex_mul,
    input  logic freeze,
    output logic mul_busy,
    output logic mul_done,
    output logic mul_hold
);

    localparam logic [MCNT_W-1:0] MCNT_LOAD = MCNT_W'(MUL_CYCLES - 3);

    mul_state_t        state;
    logic [MCNT_W-1:0] mcnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            mcnt  <= '0;
        end else if (!freeze) begin
            case (state)
                IDLE: if (ex_mul) begin
                    state <= RUN;
                    mcnt  <= MCNT_LOAD;
                end
                RUN: begin
                    if (mcnt == '0) state <= DONE;
                    else            mcnt  <= mcnt - 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ex_mul is only a start request in IDLE; in DONE it is still the finishing instruction.
    assign mul_hold = (state == RUN) || ((state == IDLE) && ex_mul);
    assign mul_done = (state == DONE);
    assign mul_busy = mul_hold || mul_done;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: dmem back-pressure > multiply > redirect > load-use.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int SHADOW     = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic ld_hazard,
    input  logic ex_mul,
    input  logic ex_redirect,
    input  logic dmem_busy,
    output logic pc_stall,
    output logic if_id_stall,
    output logic id_ex_stall,
    output logic ex_mem_stall,
    output logic mem_wb_stall,
    output logic if_id_flush,
    output logic id_ex_flush,
    output logic ex_mem_flush,
    output logic mul_busy,
    output logic mul_done
);

    logic              seq_busy;
    logic              seq_done;
    logic              mul_hold;
    logic [SCNT_W-1:0] scnt;
    pipe_ctrl_t        ctrl;

    mul_sequencer #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clock    (clock),
        .reset    (reset),
        .ex_mul   (ex_mul),
        .freeze   (dmem_busy),
        .mul_busy (seq_busy),
        .mul_done (seq_done),
        .mul_hold (mul_hold)
    );

    logic redirect_take;
    logic ld_take;
    logic shadow_on;

    assign redirect_take = ex_redirect && !seq_busy;
    assign ld_take       = ld_hazard && !seq_busy && !ex_redirect;
    assign shadow_on     = (scnt != '0);

    // The shadow keeps counting under a multiply: IF/ID is held, so the flush still lands.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scnt <= '0;
        end else if (!dmem_busy) begin
            if (redirect_take)  scnt <= SCNT_W'(SHADOW);
            else if (shadow_on) scnt <= scnt - 1'b1;
        end
    end

    // NOTE: defaulting ctrl first keeps this block free of inferred latches.
    always_comb begin
        ctrl = '0;
        if (!reset) begin
            ctrl = '0;
        end else if (dmem_busy) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_stall = 1'b1;
            ctrl.mem_wb_stall = 1'b1;
        end else begin
            ctrl.if_id_flush = shadow_on || redirect_take;
            if (mul_hold) begin
                ctrl.pc_stall     = 1'b1;
                ctrl.if_id_stall  = 1'b1;
                ctrl.id_ex_stall  = 1'b1;
                ctrl.ex_mem_flush = 1'b1;
            end else if (redirect_take) begin
                ctrl.id_ex_flush = 1'b1;
            end else if (ld_take) begin
                ctrl.pc_stall    = 1'b1;
                ctrl.if_id_stall = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end
        end
    end

    assign pc_stall     = ctrl.pc_stall;
    assign if_id_stall  = ctrl.if_id_stall;
    assign id_ex_stall  = ctrl.id_ex_stall;
    assign ex_mem_stall = ctrl.ex_mem_stall;
    assign mem_wb_stall = ctrl.mem_wb_stall;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign mul_busy     = reset && seq_busy;
    assign mul_done     = reset && seq_done;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl with MUL_CYCLES=4, SHADOW=1.
module tb_pipe_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ld_hazard = 1'b0, ex_mul = 1'b0, ex_redirect = 1'b0, dmem_busy = 1'b0;
    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mul_busy, mul_done;

    pipe_ctrl #(.MUL_CYCLES(4), .SHADOW(1)) dut (
        .clock        (clock),
        .reset        (reset),
        .ld_hazard    (ld_hazard),
        .ex_mul       (ex_mul),
        .ex_redirect  (ex_redirect),
        .dmem_busy    (dmem_busy),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .id_ex_stall  (id_ex_stall),
        .ex_mem_stall (ex_mem_stall),
        .mem_wb_stall (mem_wb_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .mul_busy     (mul_busy),
        .mul_done     (mul_done)
    );

    always #5 clock = ~clock;

    // Bit order: pc, if_id, id_ex, ex_mem, mem_wb stalls | if_id, id_ex, ex_mem flushes | busy, done
    localparam logic [9:0] ZERO   = 10'b00000_000_00;
    localparam logic [9:0] MHOLD  = 10'b11100_001_10;
    localparam logic [9:0] MDONE  = 10'b00000_000_11;
    localparam logic [9:0] BUSY_M = 10'b11111_000_10;
    localparam logic [9:0] BUSY_I = 10'b11111_000_00;
    localparam logic [9:0] REDIR  = 10'b00000_110_00;
    localparam logic [9:0] SHADW  = 10'b00000_100_00;
    localparam logic [9:0] LDUSE  = 10'b11000_010_00;
    localparam logic [9:0] MH_SH  = 10'b11100_101_10;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic [9:0] act;

    assign act = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                  if_id_flush, id_ex_flush, ex_mem_flush, mul_busy, mul_done};

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", name, got, want);
        end
    endtask

    // Apply one cycle of inputs and queue the response expected for that cycle.
    task automatic step(input string name, input logic rst, input logic mul, input logic redir,
                        input logic ld, input logic busy, input logic [9:0] exp);
        exp_t e;
        reset       = rst;
        ex_mul      = mul;
        ex_redirect = redir;
        ld_hazard   = ld;
        dmem_busy   = busy;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Monitor: the controller presents a response every cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, act, e.exp);
            end
        end
    end

    always @(negedge clock) begin
        if (reset && ex_redirect)
            assert (dut.u_mul.state == pipe_pkg::IDLE)
                else $error("ex_redirect issued while a multiply occupies EX");
    end

    initial begin
        int wait_cycles;
        @(posedge clock);
        #1;
        // Reset held with inputs toggling
        step("rst_c0", 0, 1, 0, 1, 1, ZERO);
        step("rst_c1", 0, 0, 1, 1, 0, ZERO);
        step("rst_c2", 0, 1, 1, 0, 1, ZERO);
        // Multiply with ex_mul held through DONE
        step("m1_start", 1, 1, 0, 0, 0, MHOLD);
        step("m1_run1",  1, 1, 0, 0, 0, MHOLD);
        step("m1_run2",  1, 1, 0, 0, 0, MHOLD);
        step("m1_done",  1, 1, 0, 0, 0, MDONE);
        step("m1_after", 1, 0, 0, 0, 0, ZERO);
        step("m2_start", 1, 1, 0, 0, 0, MHOLD);
        step("m2_run1",  1, 1, 0, 0, 0, MHOLD);
        step("m2_run2",  1, 1, 0, 0, 0, MHOLD);
        step("m2_done",  1, 1, 0, 0, 0, MDONE);
        step("m2_after", 1, 0, 0, 0, 0, ZERO);
        // Multiply stretched by two dmem_busy cycles
        step("m3_start", 1, 1, 0, 0, 0, MHOLD);
        step("m3_busy1", 1, 1, 0, 0, 1, BUSY_M);
        step("m3_busy2", 1, 1, 0, 0, 1, BUSY_M);
        step("m3_run1",  1, 1, 0, 0, 0, MHOLD);
        step("m3_run2",  1, 1, 0, 0, 0, MHOLD);
        step("m3_done",  1, 1, 0, 0, 0, MDONE);
        step("m3_after", 1, 0, 0, 0, 0, ZERO);
        // Redirect with simultaneous load-use
        step("rd_cyc",   1, 0, 1, 1, 0, REDIR);
        step("rd_shad",  1, 0, 0, 0, 0, SHADW);
        step("rd_end",   1, 0, 0, 0, 0, ZERO);
        // Two load-use cycles
        step("ld_c0",    1, 0, 0, 1, 0, LDUSE);
        step("ld_c1",    1, 0, 0, 1, 0, LDUSE);
        step("ld_end",   1, 0, 0, 0, 0, ZERO);
        // Redirect under dmem_busy is frozen out, scnt stays 0
        step("rd_frz",   1, 0, 1, 1, 1, BUSY_I);
        step("rd_frz_n", 1, 0, 0, 0, 0, ZERO);
        // Multiply start during the redirect shadow
        step("rs_redir", 1, 0, 1, 0, 0, REDIR);
        step("rs_mstart",1, 1, 0, 0, 0, MH_SH);
        step("rs_run1",  1, 1, 0, 0, 0, MHOLD);
        step("rs_run2",  1, 1, 0, 0, 0, MHOLD);
        step("rs_done",  1, 1, 0, 0, 0, MDONE);
        step("rs_after", 1, 0, 0, 0, 0, ZERO);
        // Reset asserted during the second RUN cycle
        step("rm_start", 1, 1, 0, 0, 0, MHOLD);
        step("rm_run1",  1, 1, 0, 0, 0, MHOLD);
        step("rm_rst0",  0, 1, 0, 0, 0, ZERO);
        step("rm_rst1",  0, 1, 0, 0, 0, ZERO);
        step("rm_rel",   1, 0, 0, 0, 0, ZERO);
        step("rm_idle",  1, 0, 0, 0, 0, ZERO);
        // Short reset pulse inside a cycle must clear RUN before the next edge
        step("rp_start", 1, 1, 0, 0, 0, MHOLD);
        step("rp_run1",  1, 1, 0, 0, 0, MHOLD);
        begin
            exp_t e;
            ex_mul = 1'b0;
            reset  = 1'b0;
            #2;
            reset  = 1'b1;
            e.name = "rp_async";
            e.exp  = ZERO;
            sb.push_back(e);
            @(posedge clock);
            #1;
        end
        step("rp_idle",  1, 0, 0, 0, 0, ZERO);
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clock);
            wait_cycles++;
        end
        check("sb_drain", 10'(sb.size()), 10'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the five-stage pipeline. It sequences multi-cycle multiplies in EX, and handles load-use hazards, EX-resolved redirects and data-memory back-pressure. It drives the per-stage hold and bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers and the IFU stall, which replaces ad-hoc OR-ing of stall sources at the top level.

## Interface
- MUL_CYCLES, 4: total cycles a multiply occupies EX, including its completion cycle; legal range 3..16.
- SHADOW, 1: extra cycles IF/ID is flushed after a redirect, covering IMEM fetch latency; legal range 0..3.

- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- ld_hazard  in  1  ID reports a load-use dependency on the instruction in EX.
- ex_mul  in  1  instruction in EX is a multiply.
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle.
- dmem_busy  in  1  data memory cannot complete the MEM-stage access this cycle.
- pc_stall  out  1  IFU holds PC.
- if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  out  1 each  pipe register holds its contents.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  pipe register loads a bubble (all control bits 0).
- mul_busy  out  1  a multiply is in progress (states RUN/DONE, or the IDLE start cycle).
- mul_done  out  1  multiply result valid in EX this cycle.

## Operation
- States: IDLE, RUN, DONE. Down-counter mcnt is 4 bits. Shadow counter scnt is 2 bits.
- All outputs are combinational from state, counters and current inputs.
- Priority, evaluated every cycle: dmem_busy > multiply > redirect > load-use.

Cases:
- **dmem_busy=1:** all five stall outputs are 1 and all flushes are 0. State, mcnt and scnt are frozen.
- **IDLE with ex_mul=1:**
  - pc_stall, if_id_stall, id_ex_stall, ex_mem_flush and mul_busy are 1.
  - Next state is RUN with mcnt = MUL_CYCLES-3.
- **RUN:** same outputs as the IDLE start cycle. mcnt decrements each cycle; when mcnt==0 the next state is DONE.
- **DONE:**
  - mul_done=1, mul_busy=1, no stalls; EX/MEM captures the product.
  - ex_mul is ignored here because it is still the same instruction.
  - Next state is IDLE.
- **ex_redirect=1 (IDLE, no multiply start):**
  - if_id_flush=1 and id_ex_flush=1.
  - scnt is loaded with SHADOW.
  - ld_hazard is ignored, since the dependent instruction is being flushed.
- **scnt>0 (IDLE, no new redirect):** if_id_flush=1 and scnt decrements. A new redirect reloads scnt.
- **ld_hazard=1 (IDLE, no redirect):** pc_stall=1, if_id_stall=1, id_ex_flush=1 for that cycle.
- ex_redirect in RUN or DONE is illegal; the bench asserts it never occurs.

Combinations:
- A multiply start while scnt>0: the multiply stall takes effect, and scnt continues decrementing, so IF/ID flush still completes because IF/ID is held. if_id_flush takes precedence over if_id_stall in the register.
- mem_wb_stall and ex_mem_stall are asserted only under dmem_busy.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, mcnt=0, scnt=0; every output is 0 while reset=0.
- Reset mid-multiply returns to IDLE immediately and no mul_done is produced.
- A multiply holds EX for exactly MUL_CYCLES cycles with dmem_busy=0: MUL_CYCLES-1 stall cycles plus 1 DONE cycle. Each dmem_busy cycle extends this by one.
- Redirect flushes ID/EX on 1 edge and IF/ID on 1+SHADOW consecutive edges.
- Load-use inserts exactly one bubble per cycle ld_hazard is high.

## Structure
- Shared package pipe_pkg holds:
  - typedef enum mul_state_t {IDLE, RUN, DONE};
  - the width constants MCNT_W=4 and SCNT_W=2;
  - the struct pipe_ctrl_t bundling the stall/flush bits, for top-level wiring.
- One sub-module, mul_sequencer, contains the state machine and mcnt and outputs mul_busy/mul_done/mul_hold. Redirect, shadow and priority logic stay in pipe_ctrl.

## Test plan
- Reset held low for 3 cycles, with all inputs toggling → all outputs 0. Release, then ex_mul=1 → pc_stall rises in the same cycle.
- MUL_CYCLES=4, ex_mul held high → stall outputs 1 for 3 cycles, mul_done on the 4th, no restart in the 5th cycle. A second multiply then restarts.
- Multiply with dmem_busy pulsed for 2 cycles in RUN → mul_done arrives 6 cycles after the start, and all stalls are 1 during the busy cycles.
- ex_redirect and ld_hazard in the same cycle, SHADOW=1 → id_ex_flush 1 cycle, if_id_flush 2 cycles, pc_stall 0.
- ld_hazard for 2 consecutive cycles → 2 id_ex_flush bubbles, pc_stall and if_id_stall high for 2 cycles.
- reset asserted in the 2nd RUN cycle → outputs drop to 0 asynchronously and mul_done never asserts.
